cim_col_accum: RTL and testbench
================================

# cim_col_accum

Column-side consumer of CIM cell outputs. Takes the per-row `mac_result_out`/`out_data_valid` pairs from one column of `NUM_ROWS` CIM cells, reduces them through a registered adder tree, and accumulates successive beats into a dot-product result. The result is presented on a valid/ready output port. The block sits between a CIM column and the column output buffer / post-processing stage.

## Interface
Parameters:
- `DATA_WIDTH`, 9: cell data-line width; product width `PROD_W = 2*(DATA_WIDTH-1)`, i.e. 16.
- `NUM_ROWS`, 8: cells per column; must be a power of 2, ≥2. `L = log2(NUM_ROWS)`.
- `ACC_WIDTH`, 32: accumulator/result width; must be ≥ `PROD_W+L`.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: input beat enable.
- `mac_result_in` in `NUM_ROWS*PROD_W`: row r product at bits `[r*PROD_W +: PROD_W]`, unsigned.
- `in_valid` in `NUM_ROWS`: per-row `out_data_valid` from the cells.
- `acc_last` in 1: beat closes the current accumulation group.
- `acc_clear` in 1: flush pipeline and accumulator.
- `in_ready` out 1: beat can be accepted.
- `out_data` out `ACC_WIDTH`: group result.
- `out_ovf` out 1: group exceeded `ACC_WIDTH` range.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.

## Operation
- Beat accepted when `en && in_ready && (|in_valid || acc_last)`. Rows with `in_valid[r]=0` contribute 0. A `last` beat with no valid rows is legal and contributes a zero sum.
- Adder tree: `L` registered stages, each pairwise-summing the previous stage and widening by 1 bit. Tree output width is `PROD_W+L`. Each stage carries a valid bit and a last tag.
- Accumulator FSM:
  - IDLE: acc=0, no open group. A tree-valid non-last beat loads acc=sum and moves to ACCUM. A tree-valid last beat produces the output directly and stays in IDLE.
  - ACCUM: non-last beat sets acc+=sum. Last beat writes `out_data` = acc+sum, clears acc, and returns to IDLE.
- On group completion, `out_ovf` = OR of every overflow event in the group, and `out_valid` is set to 1.
- Stall: `stall = out_valid && !out_ready`. While stalled, all tree stages and the accumulator hold, and `in_ready=0`. Otherwise `in_ready=1`.
- Output handshake: result is transferred when `out_valid && out_ready`. If no new result completes that cycle, `out_valid` falls to 0. If a new result completes in the same cycle, it loads and `out_valid` stays 1.
- `acc_clear` (synchronous, highest priority):
  - Zeroes all tree valid bits and acc.
  - Clears the group overflow flag.
  - Forces the FSM to IDLE.
  - Drops any beat presented in the same cycle.
  - Does not touch `out_data`, `out_valid` or `out_ovf`.
- `en=0`: no new beat enters. Beats already in flight keep draining.

## Timing
- Reset values: `out_data`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1, acc=0, all tree valid bits=0, FSM=IDLE.
- Latency: a beat accepted at edge T reaches the accumulator at edge T+L. If it is the last beat, `out_valid` is high after edge T+L+1. With `NUM_ROWS=8` this is 4 cycles.
- Throughput: 1 beat/cycle when not stalled.
- Reset mid-group discards all in-flight data and any held result.

## Configuration
- `CIM_ACC_SAT_EN` defined: the accumulator and final sum saturate at 2^ACC_WIDTH−1 on overflow, and `out_ovf=1`.
- `CIM_ACC_SAT_EN` undefined: they wrap modulo 2^ACC_WIDTH, and `out_ovf=1` is still reported.

## Test plan
- Reset: assert `rst_n=0` mid-stream. Required: `out_valid=0`, `out_data=0`, `in_ready=1`. The first group after release gives a clean result.
- Single beat: all 8 rows = 65025 (255×255), `in_valid=8'hFF`, `acc_last=1`. Required: `out_data=520200`, `out_ovf=0`, `out_valid` high 4 cycles after acceptance.
- Masked multi-beat: 3 beats, each with `in_valid=8'h0F` and all rows=100, with `en=0` bubbles between beats. Required: `out_data=1200`.
- Backpressure: hold `out_ready=0` after group A (=10) and present group B (=20). Required: `in_ready=0` while stalled and `out_data` held at 10. After `out_ready=1`: 10 then 20 in order, nothing lost or duplicated.
- Overflow with `ACC_WIDTH=20`: 3 beats of 8×65025. With `CIM_ACC_SAT_EN`: `out_data=1048575`, `out_ovf=1`. Without: `out_data=1560600 mod 2^20 = 512024`, `out_ovf=1`.
- `acc_clear` mid-group, then a 1-beat group of 8×1. Required: `out_data=8`, `out_ovf=0`. A result already held on the output port is unaffected.

Source files
------------

// File: rtl/cim_col_accum.sv
// -----------------------------------------------------------------------------
// cim_col_accum
//
// Column-side consumer of CIM cell outputs. One beat carries the products of
// all NUM_ROWS cells of a column. The masked products are captured, reduced
// through a registered pairwise adder tree, and accumulated over a group of
// beats. The group closes on a beat tagged acc_last, and the dot-product result
// is offered on a valid/ready output port.
//
// Optional feature (compile-time macro):
//   CIM_ACC_SAT_EN  defined   -> accumulator and final sum saturate at
//                                2^ACC_WIDTH-1 on overflow
//                   undefined -> accumulator and final sum wrap modulo
//                                2^ACC_WIDTH
//   out_ovf reports a group overflow in both builds.
//
// Ports:
//   clk            in   clock (single domain)
//   rst_n          in   asynchronous active-low reset
//   en             in   input beat enable
//   mac_result_in  in   row r product at [r*PROD_W +: PROD_W], unsigned
//   in_valid       in   per-row product valid; invalid rows contribute 0
//   acc_last       in   beat closes the current accumulation group
//   acc_clear      in   synchronous flush of pipeline and accumulator
//   in_ready       out  beat can be accepted (low while the output stalls)
//   out_data       out  group result
//   out_ovf        out  group exceeded the ACC_WIDTH range
//   out_valid      out  result valid
//   out_ready      in   downstream accepts the result
// -----------------------------------------------------------------------------
module cim_col_accum #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_ROWS   = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic [NUM_ROWS*2*(DATA_WIDTH-1)-1:0]    mac_result_in,
    input  logic [NUM_ROWS-1:0]                     in_valid,
    input  logic                                    acc_last,
    input  logic                                    acc_clear,
    output logic                                    in_ready,
    output logic [ACC_WIDTH-1:0]                    out_data,
    output logic                                    out_ovf,
    output logic                                    out_valid,
    input  logic                                    out_ready
);

    localparam int PROD_W = 2 * (DATA_WIDTH - 1);
    localparam int L      = $clog2(NUM_ROWS);
    localparam int TREE_W = PROD_W + L;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    logic                  stall;
    logic                  beat_accept;

    // Stage 0 captures the masked row products; stage s (1..L) holds
    // NUM_ROWS>>s partial sums. Every node is kept at the full tree width,
    // which always holds the pairwise sums without truncation.
    logic [TREE_W-1:0]     row_masked [NUM_ROWS];
    logic [TREE_W-1:0]     tree_reg   [0:L][0:NUM_ROWS-1];
    logic [L:0]            vld_reg;
    logic [L:0]            last_reg;

    state_t                state_reg, state_next;
    logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
    logic                  grp_ovf_reg, grp_ovf_next;
    logic [ACC_WIDTH:0]    sum_wide;
    logic [ACC_WIDTH-1:0]  sum_final;
    logic                  beat_ovf;
    logic                  res_load;
    logic                  res_ovf;

    logic [ACC_WIDTH-1:0]  out_data_reg;
    logic                  out_ovf_reg;
    logic                  out_valid_reg;

    assign stall       = out_valid_reg && !out_ready;
    assign in_ready    = !stall;
    assign beat_accept = en && in_ready && ((|in_valid) || acc_last);

    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_valid = out_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_mask
            assign row_masked[gi] = in_valid[gi]
                ? {{L{1'b0}}, mac_result_in[gi*PROD_W +: PROD_W]}
                : '0;
        end
    endgenerate

    // Capture + adder tree. A clear only kills the valid bits; stale data in
    // the stages is harmless because nothing downstream looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg  <= '0;
            last_reg <= '0;
            for (int s = 0; s <= L; s++) begin
                for (int n = 0; n < NUM_ROWS; n++) begin
                    tree_reg[s][n] <= '0;
                end
            end
        end else if (acc_clear) begin
            vld_reg <= '0;
        end else if (!stall) begin
            vld_reg[0]  <= beat_accept;
            last_reg[0] <= acc_last;
            for (int n = 0; n < NUM_ROWS; n++) begin
                tree_reg[0][n] <= row_masked[n];
            end
            for (int s = 1; s <= L; s++) begin
                vld_reg[s]  <= vld_reg[s-1];
                last_reg[s] <= last_reg[s-1];
                for (int n = 0; n < (NUM_ROWS >> s); n++) begin
                    tree_reg[s][n] <= tree_reg[s-1][2*n] + tree_reg[s-1][2*n+1];
                end
            end
        end
    end

    // Accumulator next-state logic. In IDLE the running sum is taken as zero,
    // so a lone last beat yields the tree sum directly.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        grp_ovf_next = grp_ovf_reg;
        res_load     = 1'b0;

        sum_wide = {1'b0, ((state_reg == S_ACCUM) ? acc_reg : {ACC_WIDTH{1'b0}})}
                 + {{(ACC_WIDTH + 1 - TREE_W){1'b0}}, tree_reg[L][0]};
        beat_ovf = sum_wide[ACC_WIDTH];
`ifdef CIM_ACC_SAT_EN
        sum_final = beat_ovf ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
        sum_final = sum_wide[ACC_WIDTH-1:0];
`endif
        res_ovf = grp_ovf_reg | beat_ovf;

        if (acc_clear) begin
            state_next   = S_IDLE;
            acc_next     = '0;
            grp_ovf_next = 1'b0;
        end else if (vld_reg[L] && !stall) begin
            if (last_reg[L]) begin
                res_load     = 1'b1;
                state_next   = S_IDLE;
                acc_next     = '0;
                grp_ovf_next = 1'b0;
            end else begin
                state_next   = S_ACCUM;
                acc_next     = sum_final;
                grp_ovf_next = res_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            acc_reg     <= '0;
            grp_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            grp_ovf_reg <= grp_ovf_next;
        end
    end

    // Output register. A completing group can only load while not stalled,
    // so a held result is never overwritten before it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            if (res_load) begin
                out_data_reg  <= sum_final;
                out_ovf_reg   <= res_ovf;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cim_col_accum.sv
module tb_cim_col_accum;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] mac_result_in;
    logic [7:0]   in_valid;
    logic         acc_last;
    logic         acc_clear;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_ovf;
    logic         out_valid;
    logic         out_ready;

    logic         in_ready20;
    logic [19:0]  out_data20;
    logic         out_ovf20;
    logic         out_valid20;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_data [$];
    logic        exp_ovf  [$];

    cim_col_accum #(.DATA_WIDTH(9), .NUM_ROWS(8), .ACC_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mac_result_in(mac_result_in),
        .in_valid(in_valid), .acc_last(acc_last), .acc_clear(acc_clear),
        .in_ready(in_ready), .out_data(out_data), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    // Narrow-accumulator instance sharing the same stimulus, used for overflow.
    cim_col_accum #(.DATA_WIDTH(9), .NUM_ROWS(8), .ACC_WIDTH(20)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .en(en), .mac_result_in(mac_result_in),
        .in_valid(in_valid), .acc_last(acc_last), .acc_clear(acc_clear),
        .in_ready(in_ready20), .out_data(out_data20), .out_ovf(out_ovf20),
        .out_valid(out_valid20), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: samples 1 ns before each rising edge.
    always begin
        logic [31:0] ed;
        logic        eo;
        @(negedge clk);
        #4;
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_data.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got data=%0d ovf=%0b, expected none", out_data, out_ovf);
            end else begin
                ed = exp_data.pop_front();
                eo = exp_ovf.pop_front();
                if (out_data !== ed || out_ovf !== eo) begin
                    n_fail++;
                    $display("FAIL result: got data=%0d ovf=%0b, expected data=%0d ovf=%0b",
                             out_data, out_ovf, ed, eo);
                end else begin
                    $display("result ok: data=%0d ovf=%0b", out_data, out_ovf);
                end
            end
        end
    end

    task automatic set_beat(input logic [15:0] val, input logic [7:0] mask, input logic last);
        for (int r = 0; r < 8; r++) mac_result_in[r*16 +: 16] = val;
        in_valid = mask;
        acc_last = last;
        en       = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [15:0] val, input logic [7:0] mask, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
        end
        set_beat(val, mask, last);
        @(negedge clk);
        $display("beat sent: row=%0d mask=%h last=%0b", val, mask, last);
    endtask

    task automatic drop_beat();
        en       = 1'b0;
        acc_last = 1'b0;
        in_valid = '0;
    endtask

    task automatic push_exp(input logic [31:0] d, input logic o);
        exp_data.push_back(d);
        exp_ovf.push_back(o);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_data.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_data.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d, expected 0", exp_data.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; acc_last = 0; acc_clear = 0; in_valid = '0;
        mac_result_in = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: valid=%0b data=%0d rdy=%0b ovf=%0b, expected 0 0 1 0",
                     out_valid, out_data, in_ready, out_ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Held result plus an open group, then reset mid-stream.
        out_ready = 1'b0;
        send_beat(16'd9, 8'h01, 1'b1);
        send_beat(16'd5, 8'hFF, 1'b0);
        drop_beat();
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd9) begin
            n_fail++;
            $display("FAIL reset_pre_held: valid=%0b data=%0d, expected 1 9", out_valid, out_data);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b data=%0d rdy=%0b, expected 0 0 1",
                     out_valid, out_data, in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        $display("reset test done");
    endtask

    task automatic test_single_beat();
        int lat = 0;
        push_exp(32'd520200, 1'b0);
        send_beat(16'd65025, 8'hFF, 1'b1);
        drop_beat();
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, expected 4", lat);
        end
        wait_empty();
    endtask

    task automatic test_masked_multi();
        push_exp(32'd1200, 1'b0);
        send_beat(16'd100, 8'h0F, 1'b0);
        drop_beat();
        @(negedge clk);
        send_beat(16'd100, 8'h0F, 1'b0);
        drop_beat();
        repeat (2) @(negedge clk);
        send_beat(16'd100, 8'h0F, 1'b1);
        drop_beat();
        wait_empty();
    endtask

    task automatic test_backpressure();
        int n = 0;
        out_ready = 1'b0;
        push_exp(32'd10, 1'b0);
        push_exp(32'd20, 1'b0);
        send_beat(16'd10, 8'h01, 1'b1);
        drop_beat();
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        set_beat(16'd20, 8'h01, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd10) begin
                n_fail++;
                $display("FAIL stall_hold: rdy=%0b valid=%0b data=%0d, expected 0 1 10",
                         in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        drop_beat();
        wait_empty();
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_duplicate: valid=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) push_exp(32'(8 * k), 1'b0);
        push_exp(32'd24, 1'b0);
        push_exp(32'd24, 1'b0);
        for (int k = 1; k <= 4; k++) send_beat(16'(k), 8'hFF, 1'b1);
        send_beat(16'd1, 8'hFF, 1'b0);
        send_beat(16'd2, 8'hFF, 1'b1);
        send_beat(16'd3, 8'hFF, 1'b1);
        drop_beat();
        wait_empty();
    endtask

    task automatic test_overflow();
        int n = 0;
        logic [19:0] ed;
`ifdef CIM_ACC_SAT_EN
        ed = 20'd1048575;
`else
        ed = 20'd512024;
`endif
        push_exp(32'd1560600, 1'b0);
        send_beat(16'd65025, 8'hFF, 1'b0);
        send_beat(16'd65025, 8'hFF, 1'b0);
        send_beat(16'd65025, 8'hFF, 1'b1);
        drop_beat();
        while (!out_valid20 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (out_valid20 !== 1'b1 || out_data20 !== ed || out_ovf20 !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow20: valid=%0b data=%0d ovf=%0b, expected 1 %0d 1",
                     out_valid20, out_data20, out_ovf20, ed);
        end
        wait_empty();
    endtask

    task automatic test_acc_clear();
        int n = 0;
        // Open group: one beat in the accumulator, one in the tree.
        send_beat(16'd50, 8'hFF, 1'b0);
        drop_beat();
        repeat (5) @(negedge clk);
        send_beat(16'd50, 8'hFF, 1'b0);
        drop_beat();
        set_beat(16'd7, 8'hFF, 1'b1);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        drop_beat();
        repeat (6) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drop: valid=%0b, expected 0", out_valid);
        end
        push_exp(32'd8, 1'b0);
        send_beat(16'd1, 8'hFF, 1'b1);
        drop_beat();
        while (!out_valid20 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (out_data20 !== 20'd8 || out_ovf20 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_group20: data=%0d ovf=%0b, expected 8 0", out_data20, out_ovf20);
        end
        wait_empty();
        // Held result must survive a clear.
        out_ready = 1'b0;
        push_exp(32'd3, 1'b0);
        send_beat(16'd3, 8'h01, 1'b1);
        drop_beat();
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd3 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_held: valid=%0b data=%0d ovf=%0b, expected 1 3 0",
                     out_valid, out_data, out_ovf);
        end
        out_ready = 1'b1;
        wait_empty();
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_masked_multi();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_acc_clear();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
